// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline interlock controller.
//   - RV32 base opcodes used for hazard classification
//   - forward-select encodings driven onto fwd_a / fwd_b
//   - interlock FSM states
//   - shadow-slot and opcode-class structs, plus the RAW match helper
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Slot rd is stored at a fixed width so the struct can live here;
  // instances zero-extend their REG_W-wide indices (REG_W <= RD_W_MAX).
  localparam int unsigned RD_W_MAX = 8;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                wen;
    logic                is_load;
    logic                is_ecall;
  } slot_t;

  typedef struct packed {
    logic use_rs1;
    logic use_rs2;
    logic wen;
    logic is_load;
    logic is_ecall;
  } op_info_t;

  // RAW match of one source index against one in-flight producer; x0 never matches.
  function automatic logic slot_hit(slot_t s, logic [RD_W_MAX-1:0] src);
    return s.valid && s.wen && (src != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_op_class.sv
// op_class: combinational opcode classifier.
//   opcode : 7-bit major opcode of the instruction in decode
//   info   : {use_rs1, use_rs2, wen, is_load, is_ecall}
// wen here is the raw class write-enable; the rd != 0 qualification is left
// to the consumer, which has the rd field.
module op_class
  import hazard_pkg::*;
(
  input  logic [6:0] opcode,
  output op_info_t   info
);

  always_comb begin
    info = '0;
    case (opcode)
      OP_R:      begin info.use_rs1 = 1'b1; info.use_rs2 = 1'b1; info.wen = 1'b1; end
      OP_STORE,
      OP_BRANCH: begin info.use_rs1 = 1'b1; info.use_rs2 = 1'b1; end
      OP_I,
      OP_JALR:   begin info.use_rs1 = 1'b1; info.wen = 1'b1; end
      OP_LOAD:   begin info.use_rs1 = 1'b1; info.wen = 1'b1; info.is_load = 1'b1; end
      OP_JAL,
      OP_LUI,
      OP_AUIPC:  info.wen = 1'b1;
      OP_SYSTEM: info.is_ecall = 1'b1;
      default:   info = '0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: interlock controller for the 5-stage pipeline, beside decode.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   d_valid/d_opcode/d_rd/d_rs1/d_rs2 : instruction currently in ID
//   e_redirect            : taken branch/jump in EX
//   stall_f, stall_d      : hold PC / hold IF/ID
//   flush_d, bubble_e     : invalidate IF/ID / load NOP into ID/EX
//   fwd_a, fwd_b          : registered EX operand selects (00 rf, 01 MEM, 10 WB)
//   halt                  : sticky, set once an ECALL has drained the pipe
// EX/MEM/WB occupancy is shadowed in three slots; the regfile bypasses
// same-cycle WB writes, so only EX and MEM are compared.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned REG_W  = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             d_valid,
  input  logic [6:0]       d_opcode,
  input  logic [REG_W-1:0] d_rd,
  input  logic [REG_W-1:0] d_rs1,
  input  logic [REG_W-1:0] d_rs2,
  input  logic             e_redirect,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             bubble_e,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halt
);

  op_info_t info;
  state_t   state;
  slot_t    ex_s, mem_s, wb_s, ex_n;

  logic [RD_W_MAX-1:0] rd_x, rs1_x, rs2_x;
  logic run, ex_a, ex_b, mem_a, mem_b, hazard, redirect, stall, issue;
  logic [1:0] fa_n, fb_n;
  logic unused_slot_bits;

  op_class u_op_class (
    .opcode (d_opcode),
    .info   (info)
  );

  assign rd_x  = RD_W_MAX'(d_rd);
  assign rs1_x = RD_W_MAX'(d_rs1);
  assign rs2_x = RD_W_MAX'(d_rs2);

  assign run   = (state == RUN);
  assign ex_a  = info.use_rs1 & slot_hit(ex_s,  rs1_x);
  assign ex_b  = info.use_rs2 & slot_hit(ex_s,  rs2_x);
  assign mem_a = info.use_rs1 & slot_hit(mem_s, rs1_x);
  assign mem_b = info.use_rs2 & slot_hit(mem_s, rs2_x);

  // With forwarding only a load in EX cannot be bypassed in time; without it
  // any in-flight producer in EX or MEM holds the consumer in ID.
  assign hazard = d_valid & run &
                  (FWD_EN ? ((ex_a | ex_b) & ex_s.is_load)
                          : (ex_a | ex_b | mem_a | mem_b));

  // A redirect is only meaningful if a real branch occupies EX; it kills the
  // ID instruction, so it takes priority over any stall on that instruction.
  assign redirect = run & ex_s.valid & e_redirect;
  assign stall    = hazard & ~redirect;
  assign issue    = d_valid & run & ~hazard & ~redirect;

  assign stall_f  = stall | (state == DRAIN) | (state == HALT);
  assign stall_d  = stall | (state == HALT);
  assign flush_d  = redirect | (state == DRAIN);
  assign bubble_e = stall | redirect;

  always_comb begin
    ex_n = '0;
    fa_n = FWD_REG;
    fb_n = FWD_REG;
    if (issue) begin
      ex_n.valid    = 1'b1;
      ex_n.rd       = rd_x;
      ex_n.wen      = info.wen & (d_rd != '0);
      ex_n.is_load  = info.is_load;
      ex_n.is_ecall = info.is_ecall;
      if (FWD_EN) begin
        fa_n = ex_a ? FWD_MEM : (mem_a ? FWD_WB : FWD_REG);
        fb_n = ex_b ? FWD_MEM : (mem_b ? FWD_WB : FWD_REG);
      end
    end
  end

  assign unused_slot_bits = ^{wb_s, mem_s.is_load, mem_s.is_ecall, ex_s.is_ecall};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      ex_s  <= '0;
      mem_s <= '0;
      wb_s  <= '0;
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
      halt  <= 1'b0;
    end else begin
      wb_s  <= mem_s;
      mem_s <= ex_s;
      ex_s  <= ex_n;
      fwd_a <= fa_n;
      fwd_b <= fb_n;
      case (state)
        RUN:   if (issue && info.is_ecall) state <= DRAIN;
        DRAIN: if (!ex_s.valid && !mem_s.valid && !wb_s.valid) begin
                 state <= HALT;
                 halt  <= 1'b1;
               end
        HALT:  halt <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] SYS_OP = 7'b1110011;

  logic       clock, reset_n, d_valid, e_redirect;
  logic [6:0] d_opcode;
  logic [4:0] d_rd, d_rs1, d_rs2;

  logic       stall_f, stall_d, flush_d, bubble_e, halt;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_f0, stall_d0, flush_d0, bubble_e0, halt0;
  logic [1:0] fwd_a0, fwd_b0;

  hazard_ctrl #(.FWD_EN(1'b1), .REG_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .e_redirect(e_redirect),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .bubble_e(bubble_e),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halt(halt)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .REG_W(5)) dut0 (
    .clock(clock), .reset_n(reset_n), .d_valid(d_valid), .d_opcode(d_opcode),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .e_redirect(e_redirect),
    .stall_f(stall_f0), .stall_d(stall_d0), .flush_d(flush_d0), .bubble_e(bubble_e0),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .halt(halt0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string      tag;
    logic [8:0] exp;
    bit         sel;   // 0: forwarding instance, 1: stall-only instance
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed as {stall_f, stall_d, flush_d, bubble_e, fwd_a, fwd_b, halt}.
  function automatic logic [8:0] ev(bit sf, bit sd, bit fd, bit be,
                                    logic [1:0] fa, logic [1:0] fb, bit h);
    return {sf, sd, fd, be, fa, fb, h};
  endfunction

  // Outputs are sampled mid-cycle, well away from the rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel)
        check(e.tag, 16'({stall_f0, stall_d0, flush_d0, bubble_e0, fwd_a0, fwd_b0, halt0}), 16'(e.exp));
      else
        check(e.tag, 16'({stall_f, stall_d, flush_d, bubble_e, fwd_a, fwd_b, halt}), 16'(e.exp));
    end
  end

  task automatic step(input string tag, input bit v, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit rdr, input logic [8:0] exp, input bit sel);
    @(posedge clock);
    #1;
    d_valid = v; d_opcode = op; d_rd = rd; d_rs1 = rs1; d_rs2 = rs2; e_redirect = rdr;
    q.push_back('{tag, exp, sel});
  endtask

  task automatic idle(input string tag, input logic [8:0] exp, input bit sel);
    step(tag, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, exp, sel);
  endtask

  task automatic do_reset(input bit sel);
    @(posedge clock);
    #1;
    reset_n = 1'b0; d_valid = 1'b0; e_redirect = 1'b0;
    d_opcode = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0;
    q.push_back('{"reset", 9'd0, sel});
    @(negedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; d_valid = 1'b0; e_redirect = 1'b0;
    d_opcode = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0;

    // ADD x3,x1,x2 ; SUB x4,x3,x1 -> no stall, SUB sees fwd_a=01
    do_reset(0);
    step("add_x3",  1, R_OP, 5'd3, 5'd1, 5'd2, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    step("sub_x4",  1, R_OP, 5'd4, 5'd3, 5'd1, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    idle("sub_fwd",                                ev(0,0,0,0,2'b01,2'b00,0), 0);

    // LW x5 ; ADD x6,x5,x5 -> one stall, then fwd 10/10
    do_reset(0);
    step("lw_x5",   1, LD_OP, 5'd5, 5'd1, 5'd0, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    step("lu_stall",1, R_OP,  5'd6, 5'd5, 5'd5, 0, ev(1,1,0,1,2'b00,2'b00,0), 0);
    step("lu_issue",1, R_OP,  5'd6, 5'd5, 5'd5, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    idle("lu_fwd",                                 ev(0,0,0,0,2'b10,2'b10,0), 0);

    // ADDI x0,x0,1 ; ADD x7,x0,x0 -> x0 never matches
    do_reset(0);
    step("addi_x0", 1, I_OP, 5'd0, 5'd0, 5'd0, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    step("add_x0",  1, R_OP, 5'd7, 5'd0, 5'd0, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    idle("x0_fwd",                                ev(0,0,0,0,2'b00,2'b00,0), 0);

    // Redirect with LW x5 in EX and dependent ADD x6 in ID: flush wins
    do_reset(0);
    step("rd_lw",   1, LD_OP, 5'd5, 5'd1, 5'd0, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    step("rd_flush",1, R_OP,  5'd6, 5'd5, 5'd5, 1, ev(0,0,1,1,2'b00,2'b00,0), 0);
    step("rd_next", 1, R_OP,  5'd9, 5'd6, 5'd6, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    idle("rd_noadd",                                ev(0,0,0,0,2'b00,2'b00,0), 0);

    // e_redirect with an empty EX slot is ignored and the instruction issues
    do_reset(0);
    step("rdx_ign", 1, R_OP, 5'd3, 5'd1, 5'd2, 1, ev(0,0,0,0,2'b00,2'b00,0), 0);
    step("rdx_dep", 1, R_OP, 5'd4, 5'd3, 5'd3, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    idle("rdx_fwd",                               ev(0,0,0,0,2'b01,2'b01,0), 0);

    // ECALL together with a redirect: ECALL flushed, FSM stays in RUN
    do_reset(0);
    step("ecr_add", 1, R_OP,   5'd3, 5'd1, 5'd2, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    step("ecr_fl",  1, SYS_OP, 5'd0, 5'd0, 5'd0, 1, ev(0,0,1,1,2'b00,2'b00,0), 0);
    idle("ecr_run1",                                ev(0,0,0,0,2'b00,2'b00,0), 0);
    idle("ecr_run2",                                ev(0,0,0,0,2'b00,2'b00,0), 0);

    // ECALL drain: halt on the 4th edge after the issue edge, then sticky
    do_reset(0);
    step("ec_issue",1, SYS_OP, 5'd0, 5'd0, 5'd0, 0, ev(0,0,0,0,2'b00,2'b00,0), 0);
    for (int unsigned i = 0; i < 4; i++)
      step("ec_drain",1, R_OP, 5'd6, 5'd1, 5'd2, 1, ev(1,0,1,0,2'b00,2'b00,0), 0);
    step("ec_halt1",1, R_OP, 5'd6, 5'd1, 5'd2, 0, ev(1,1,0,0,2'b00,2'b00,1), 0);
    step("ec_halt2",1, R_OP, 5'd6, 5'd1, 5'd2, 1, ev(1,1,0,0,2'b00,2'b00,1), 0);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_halt", 16'(halt), 16'd0);
    check("async_stall", 16'({stall_f, stall_d, flush_d}), 16'd0);

    // Stall-only instance: ADD x3 ; OR x8,x3,x3 -> 2 stalls, OR issues with fwd 00
    do_reset(1);
    step("nf_add",  1, R_OP, 5'd3, 5'd1, 5'd2, 0, ev(0,0,0,0,2'b00,2'b00,0), 1);
    step("nf_st1",  1, R_OP, 5'd8, 5'd3, 5'd3, 0, ev(1,1,0,1,2'b00,2'b00,0), 1);
    step("nf_st2",  1, R_OP, 5'd8, 5'd3, 5'd3, 0, ev(1,1,0,1,2'b00,2'b00,0), 1);
    step("nf_issue",1, R_OP, 5'd8, 5'd3, 5'd3, 0, ev(0,0,0,0,2'b00,2'b00,0), 1);
    idle("nf_fwd",                                ev(0,0,0,0,2'b00,2'b00,0), 1);

    @(negedge clock);
    @(negedge clock);
    if (q.size() != 0) check("queue_drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline interlock controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Sits beside the decode stage. It consumes the decoded opcode and register fields, shadows EX/MEM/WB occupancy in an internal scoreboard, and drives the fetch/decode stalls, the decode flush, the EX bubble and the operand-forward selects.
- It also sequences ECALL shutdown: it drains the pipe, then raises a sticky halt.

Parameters:
- FWD_EN, 1: 1 = resolve EX/MEM RAW hazards by forwarding; 0 = resolve every RAW hazard against the EX or MEM slot by stalling, and fwd_a/fwd_b are held at 0.
- REG_W, 5: register index width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- d_valid  in  1  IF/ID register holds a valid instruction
- d_opcode  in  7  opcode of the instruction in ID
- d_rd  in  REG_W  destination register of the instruction in ID
- d_rs1  in  REG_W  source register 1 of the instruction in ID
- d_rs2  in  REG_W  source register 2 of the instruction in ID
- e_redirect  in  1  the branch/jump in EX is taken this cycle
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID
- flush_d  out  1  invalidate IF/ID at the next edge
- bubble_e  out  1  load a NOP into ID/EX at the next edge
- fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB result
- fwd_b  out  2  EX operand B source, same encoding as fwd_a
- halt  out  1  core halted (sticky)

Behaviour:
- Reset (async, reset_n=0): all shadow slots invalid; FSM = RUN; fwd_a = fwd_b = 00; halt = 0. Combinational outputs evaluate to 0 because the slots are empty.
- Shadow slots:
  - EX, MEM and WB each hold {valid, rd, wen, is_load, is_ecall}.
  - Every edge: WB<=MEM, MEM<=EX, EX<=(issue ? decoded ID fields : invalid).
- Opcode classes:
  - Reads rs1 and rs2: R (0110011), S (0100011), B (1100011).
  - Reads rs1 only: I-ALU (0010011), load (0000011), JALR (1100111).
  - Reads no sources: LUI, AUIPC, JAL, ECALL (1110011).
  - wen = R | I-ALU | load | JALR | JAL | LUI | AUIPC, and only when rd != 0.
  - Unknown opcode: no sources read, wen = 0.
- Hazard match: a source is "used" and its index equals a slot's rd while that slot is valid and has wen=1. Index 0 never matches.
- Load-use (RUN only): match against the EX slot with is_load=1 -> stall_f = stall_d = bubble_e = 1 for exactly 1 cycle. The consumer issues next cycle with fwd = 10.
- FWD_EN=0: any match against the EX or MEM slot stalls the same way, repeating until the slot clears.
- issue = d_valid & RUN & !stall & !e_redirect.
- Forward selects:
  - Registered at issue and valid during the consumer's EX cycle.
  - Match against the EX slot -> 01; else match against the MEM slot -> 10; else 00. The younger producer wins.
  - The regfile bypasses same-cycle WB writes, so no WB-slot compare is needed.
- Redirect (RUN, EX slot valid, e_redirect=1): flush_d = 1 and bubble_e = 1; stall_f = stall_d = 0 so the PC takes the target.
  - Redirect overrides a simultaneous load-use stall.
  - e_redirect while the EX slot is invalid is ignored.
- FSM:
  - RUN -> DRAIN: the cycle an ECALL issues.
  - DRAIN: stall_f = 1, flush_d = 1, no issue, e_redirect ignored. No branch can be older than the issued ECALL.
  - DRAIN -> HALT: the EX, MEM and WB slots are all invalid. halt rises 4 edges after the ECALL issue edge.
  - HALT: stall_f = stall_d = 1, halt = 1, no issue. Only reset exits.
- Reset mid-operation clears all slots and the FSM immediately, including in DRAIN or HALT.
- d_valid = 0 issues a bubble with no stall. A redirect and an ECALL in the same cycle: the redirect wins and the ECALL is flushed.

Decomposition:
- Shared package hazard_pkg:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM)
  - FWD_REG/FWD_MEM/FWD_WB encodings
  - FSM state encoding RUN/DRAIN/HALT
  - slot struct typedef
- One sub-module, op_class: a combinational opcode to {use_rs1, use_rs2, wen, is_load, is_ecall} lookup, also reusable by the decode stage.

Test Plan:
- ADD x3,x1,x2 then SUB x4,x3,x1 back-to-back -> no stall; SUB issues with fwd_a=01, fwd_b=00.
- LW x5,0(x1) then ADD x6,x5,x5 -> one cycle of stall_f=stall_d=bubble_e=1; ADD then issues with fwd_a=fwd_b=10.
- ADDI x0,x0,1 then ADD x7,x0,x0 -> no stall and fwd=00, since the x0 match is suppressed.
- BEQ taken (e_redirect=1) while LW x5 is in EX and a dependent ADD x6,x5 is in ID -> flush_d=1, bubble_e=1, stall_f=0; the ADD never issues.
- ECALL in ID with the pipe otherwise empty -> DRAIN, halt=0 for 3 cycles, halt=1 on the 4th edge after issue, then stuck; reset_n low -> halt=0 asynchronously.
- FWD_EN=0: ADD x3 then OR x8,x3,x3 -> 2 stall cycles; OR issues with fwd=00.
